// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward scheduler for the 5-stage pipeline with a req/ack data-memory FSM.
// Optional stall/flush performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic       resultsrcE0,
  input  logic       pcsrcE,
  input  logic [4:0] rdM,
  input  logic       regwriteM,
  input  logic       memreqM,
  input  logic       memackM,
  input  logic [4:0] rdW,
  input  logic       regwriteW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic       dmem_req,
  output logic       mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TO_LAST_I);

  logic [0:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req_raw;
  logic              memstall;
  logic              lwstall;
  logic              timeout_hit;

  // M has priority over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwriteM && (rdM == rs) && (rs != 5'd0))
      return 2'b10;
    else if (regwriteW && (rdW == rs) && (rs != 5'd0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(rs1E);
    forwardBE = fwd_sel(rs2E);
  end

  always_comb begin
    req_raw     = ((state == IDLE) && memreqM) || (state == WAIT);
    memstall    = req_raw && !memackM;
    lwstall     = resultsrcE0 && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    timeout_hit = (MEM_TIMEOUT > 0) && (state == WAIT) && !memackM && (wait_cnt == TO_LAST);
  end

  // A memory stall freezes E, so a pending branch or load-use waits until release.
  always_comb begin
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    stallM   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushW   = 1'b0;
    dmem_req = 1'b0;
    if (!reset) begin
      dmem_req = req_raw;
      if (memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memreqM && !memackM) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (memackM) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state   <= IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF) stall_cnt <= stall_cnt + 1'b1;
      if (flushE) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       resultsrcE0, pcsrcE, regwriteM, memreqM, memackM, regwriteW;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, dmem_req, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] ctl;
  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, dmem_req};

  localparam logic [7:0] CTL_NONE = 8'b0000_0000;
  localparam logic [7:0] CTL_MEMS = 8'b1111_0011;
  localparam logic [7:0] CTL_REQ  = 8'b0000_0001;
  localparam logic [7:0] CTL_LW   = 8'b1100_0100;
  localparam logic [7:0] CTL_BR   = 8'b0000_1100;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultsrcE0(resultsrcE0), .pcsrcE(pcsrcE),
    .rdM(rdM), .regwriteM(regwriteM), .memreqM(memreqM), .memackM(memackM),
    .rdW(rdW), .regwriteW(regwriteW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .dmem_req(dmem_req), .mem_err(mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultsrcE0 = 0; pcsrcE = 0; regwriteM = 0; memreqM = 0; memackM = 0; regwriteW = 0;
  endtask

  // Inputs change on the falling edge; checks run 1 ns later, clear of the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    step();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    clear_inputs();
    reset = 1'b1;
    memreqM = 1'b1;
    pcsrcE = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_NONE); end
    step();
    memreqM = 1'b0;
    pcsrcE = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
`ifdef PIPE_HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
`endif
    reset = 1'b0;
    step();
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, CTL_NONE); end
  endtask

  task automatic test_forwarding();
    step();
    clear_inputs();
    regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5; rs1E = 5; rs2E = 0;
    #1;
    checks++;
    if (forwardAE !== 2'b10 || forwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_m_prio got=%b/%b exp=10/00", forwardAE, forwardBE);
    end
    rdM = 6;
    #1;
    checks++;
    if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got=%b exp=01", forwardAE); end
    rs2E = 6;
    #1;
    checks++;
    if (forwardBE !== 2'b10) begin errors++; $display("FAIL fwd_b_m got=%b exp=10", forwardBE); end
    regwriteM = 0;
    #1;
    checks++;
    if (forwardAE !== 2'b01 || forwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_no_wm got=%b/%b exp=01/00", forwardAE, forwardBE);
    end
    rs1E = 0; rdW = 0; regwriteM = 1; rdM = 0;
    #1;
    checks++;
    if (forwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b exp=00", forwardAE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    resultsrcE0 = 1; rdE = 3; rs2D = 3; rs1D = 7;
    #1;
    checks++;
    if (ctl !== CTL_LW) begin errors++; $display("FAIL lwstall got=%b exp=%b", ctl, CTL_LW); end
    step();
    resultsrcE0 = 0; rdE = 0; rs2D = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL lw_release got=%b exp=%b", ctl, CTL_NONE); end
`ifdef PIPE_HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== CNT_W'(1) || flush_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL perf_lw got=%0d/%0d exp=1/1", stall_cnt, flush_cnt);
    end
`endif
    resultsrcE0 = 1; rdE = 0; rs1D = 0; rs2D = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL lw_rd0 got=%b exp=%b", ctl, CTL_NONE); end
  endtask

  task automatic test_branch_priority();
    step();
    clear_inputs();
    resultsrcE0 = 1; rdE = 4; rs1D = 4; pcsrcE = 1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_over_lw got=%b exp=%b", ctl, CTL_BR); end
    step();
    clear_inputs();
    pcsrcE = 1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_only got=%b exp=%b", ctl, CTL_BR); end
  endtask

  task automatic test_multicycle_mem();
    apply_reset();
    memreqM = 1;
    for (int i = 0; i < 3; i++) begin
      // Branch and load-use present mid-stall must be deferred.
      pcsrcE = (i == 1);
      resultsrcE0 = (i == 2); rdE = 2; rs1D = 2;
      #1;
      checks++;
      if (ctl !== CTL_MEMS) begin errors++; $display("FAIL mem_wait%0d got=%b exp=%b", i, ctl, CTL_MEMS); end
      step();
    end
    clear_inputs();
    memreqM = 1; memackM = 1;
    #1;
    checks++;
    if (ctl !== CTL_REQ) begin errors++; $display("FAIL mem_ack got=%b exp=%b", ctl, CTL_REQ); end
    step();
    memreqM = 0; memackM = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL mem_idle got=%b exp=%b", ctl, CTL_NONE); end
    memreqM = 1; memackM = 1;
    #1;
    checks++;
    if (ctl !== CTL_REQ) begin errors++; $display("FAIL zero_wait got=%b exp=%b", ctl, CTL_REQ); end
    step();
    memreqM = 0; memackM = 1;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL stray_ack got=%b exp=%b", ctl, CTL_NONE); end
    step();
    memackM = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE || mem_err !== 1'b0) begin
      errors++; $display("FAIL stray_ack_idle got=%b err=%b exp=%b err=0", ctl, mem_err, CTL_NONE);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    memreqM = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_MEMS || mem_err !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d got=%b err=%b exp=%b err=0", i, ctl, mem_err, CTL_MEMS);
      end
      step();
    end
    memreqM = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE || mem_err !== 1'b1) begin
      errors++; $display("FAIL to_release got=%b err=%b exp=%b err=1", ctl, mem_err, CTL_NONE);
    end
    step();
    memreqM = 1; memackM = 1;
    #1;
    checks++;
    if (ctl !== CTL_REQ || mem_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky got=%b err=%b exp=%b err=1", ctl, mem_err, CTL_REQ);
    end
    step();
    reset = 1;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL to_reset_ctl got=%b exp=%b", ctl, CTL_NONE); end
    step();
    reset = 0; memreqM = 0; memackM = 0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_clear got=%b exp=0", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    memreqM = 1;
    step();
    step();
    #1;
    checks++;
    if (ctl !== CTL_MEMS) begin errors++; $display("FAIL rw_wait got=%b exp=%b", ctl, CTL_MEMS); end
    reset = 1;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL rw_reset_cycle got=%b exp=%b", ctl, CTL_NONE); end
    step();
    reset = 0; memreqM = 0;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin errors++; $display("FAIL rw_idle got=%b exp=%b", ctl, CTL_NONE); end
`ifdef PIPE_HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== '0) begin errors++; $display("FAIL rw_perf got=%0d exp=0", stall_cnt); end
`endif
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_multicycle_mem();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
